// File: rtl/lighting_sequencer.sv
// Clocked lighting sequencer: computes lamp/shade targets from registered room inputs and
// ramps the lamp bank and window shade toward them one step at a time, with vacancy shut-off.
//   state   | meaning
//   IDLE    | lightnum equals target, step timer parked at 0
//   RAMP_UP | lightnum steps up by one every STEP_CYCLES
//   RAMP_DN | lightnum steps down by one every STEP_CYCLES
module lighting_sequencer #(
  parameter int NUM_LAMPS         = 16,
  parameter int STEP_CYCLES       = 4,
  parameter int SHADE_STEP_CYCLES = 8,
  parameter int HOLD_CYCLES       = 64,
  localparam int CNT_W            = $clog2(NUM_LAMPS + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [3:0]           tcode,
  input  logic [3:0]           ulight,
  input  logic [3:0]           room_len,
  input  logic                 occ,
  output logic [CNT_W-1:0]     lightnum,
  output logic [NUM_LAMPS-1:0] lightstate,
  output logic [3:0]           wshade,
  output logic                 busy,
  output logic                 vacant
);

  localparam int STW = $clog2(STEP_CYCLES + 1);
  localparam int SSW = $clog2(SHADE_STEP_CYCLES + 1);
  localparam int VW  = $clog2(HOLD_CYCLES + 1);
  localparam logic [STW-1:0] STEP_LAST  = STW'(STEP_CYCLES - 1);
  localparam logic [SSW-1:0] SHADE_LAST = SSW'(SHADE_STEP_CYCLES - 1);
  localparam logic [VW-1:0]  HOLD_MAX   = VW'(HOLD_CYCLES);

  typedef enum logic [1:0] {IDLE, RAMP_UP, RAMP_DN} state_t;

  state_t             state;
  logic [3:0]         r_tcode, r_ulight, r_room_len;
  logic               r_occ;
  logic [CNT_W-1:0]   tgt_lamps;
  logic [3:0]         tgt_shade;
  logic [STW-1:0]     step_tmr;
  logic [SSW-1:0]     shade_tmr;
  logic               shade_act;
  logic [VW-1:0]      vac_cnt;

  logic [3:0]         base;
  logic [4:0]         demand;
  logic               is_day;
  logic [CNT_W-1:0]   lamps_calc;
  logic [3:0]         shade_calc;
  logic               lamp_wrap, shade_wrap;
  logic [CNT_W-1:0]   ln_nx;
  logic [3:0]         sh_nx;
  logic [VW-1:0]      vac_cnt_nx;

  function automatic logic [NUM_LAMPS-1:0] therm(input logic [CNT_W-1:0] n);
    therm = '0;
    for (int i = 0; i < NUM_LAMPS; i++) therm[i] = (i < int'(n));
  endfunction

  always_comb begin
    base   = 4'(({4'b0, r_room_len} * {4'b0, r_room_len}) >> 4);
    demand = 5'(({4'b0, base} * {4'b0, r_ulight}) >> 3);
    is_day = (r_tcode >= 4'd6) && (r_tcode <= 4'd11);
    if (is_day) demand = demand >> 1;
    if ({1'b0, demand} > 6'(NUM_LAMPS)) lamps_calc = CNT_W'(NUM_LAMPS);
    else                                 lamps_calc = CNT_W'(demand);
    if (vacant) lamps_calc = '0;
    shade_calc = is_day ? 4'd15 - r_ulight : 4'd15;
  end

  // Step strobes shared by the sequential blocks so lightstate and busy track same-edge values.
  always_comb begin
    lamp_wrap  = (state != IDLE) && (step_tmr == STEP_LAST);
    shade_wrap = shade_act && (shade_tmr == SHADE_LAST);
    ln_nx = lightnum;
    if (lamp_wrap && (tgt_lamps > lightnum)) ln_nx = lightnum + CNT_W'(1);
    else if (lamp_wrap && (tgt_lamps < lightnum)) ln_nx = lightnum - CNT_W'(1);
    sh_nx = wshade;
    if (shade_wrap && (tgt_shade > wshade)) sh_nx = wshade + 4'd1;
    else if (shade_wrap && (tgt_shade < wshade)) sh_nx = wshade - 4'd1;
    if (r_occ) vac_cnt_nx = '0;
    else if (vac_cnt == HOLD_MAX) vac_cnt_nx = vac_cnt;
    else vac_cnt_nx = vac_cnt + VW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tcode    <= '0;
      r_ulight   <= '0;
      r_room_len <= '0;
      r_occ      <= 1'b0;
      tgt_lamps  <= '0;
      tgt_shade  <= '0;
      vac_cnt    <= '0;
      vacant     <= 1'b0;
      busy       <= 1'b0;
    end else begin
      r_tcode    <= tcode;
      r_ulight   <= ulight;
      r_room_len <= room_len;
      r_occ      <= occ;
      tgt_lamps  <= lamps_calc;
      tgt_shade  <= shade_calc;
      vac_cnt    <= vac_cnt_nx;
      vacant     <= (vac_cnt_nx == HOLD_MAX);
      busy       <= (ln_nx != lamps_calc) || (sh_nx != shade_calc);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      step_tmr   <= '0;
      lightnum   <= '0;
      lightstate <= '0;
    end else begin
      lightnum   <= ln_nx;
      lightstate <= therm(ln_nx);
      case (state)
        IDLE: begin
          step_tmr <= '0;
          if (tgt_lamps > lightnum) state <= RAMP_UP;
          else if (tgt_lamps < lightnum) state <= RAMP_DN;
        end
        default: begin
          if (tgt_lamps == lightnum) begin
            state    <= IDLE;
            step_tmr <= '0;
          end else if (lamp_wrap) begin
            step_tmr <= '0;
            if (ln_nx == tgt_lamps) state <= IDLE;
            else state <= (tgt_lamps > lightnum) ? RAMP_UP : RAMP_DN;
          end else begin
            // Direction follows the live target; the timer keeps running across a flip.
            step_tmr <= step_tmr + STW'(1);
            state    <= (tgt_lamps > lightnum) ? RAMP_UP : RAMP_DN;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shade_act <= 1'b0;
      shade_tmr <= '0;
      wshade    <= 4'd15;
    end else begin
      wshade <= sh_nx;
      if (!shade_act) begin
        shade_tmr <= '0;
        if (tgt_shade != wshade) shade_act <= 1'b1;
      end else if (tgt_shade == wshade) begin
        shade_act <= 1'b0;
        shade_tmr <= '0;
      end else if (shade_wrap) begin
        shade_tmr <= '0;
        shade_act <= (sh_nx != tgt_shade);
      end else begin
        shade_tmr <= shade_tmr + SSW'(1);
      end
    end
  end

endmodule
